// File: rtl/dline_bus_if.sv
// Cache line port plus 64-bit system bus port of the line adapter.
// The master modport is the adapter side; the slave modport is its environment.
interface dline_bus_if;
    logic         drequest;
    logic         dwrenable;
    logic [63:0]  daddr;
    logic [511:0] dwdata;
    logic [511:0] drdata;
    logic         ddone;
    logic         bus_req;
    logic         bus_we;
    logic [63:0]  bus_addr;
    logic [63:0]  bus_wdata;
    logic         bus_ready;
    logic         bus_rvalid;
    logic [63:0]  bus_rdata;

    modport master (
        input  drequest, dwrenable, daddr, dwdata, bus_ready, bus_rvalid, bus_rdata,
        output drdata, ddone, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output drequest, dwrenable, daddr, dwdata, bus_ready, bus_rvalid, bus_rdata,
        input  drdata, ddone, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/dline_bus.sv
// Moves one 64-byte cache line over a 64-bit bus as eight beats; DLINE_BUS_PERF_EN adds line counters.
// Latency: read ddone 10 cycles after drequest, write 9 cycles, when the bus never stalls.
// Backpressure: command/beats held stable while bus_ready is low; rvalid gaps simply stretch the read.
module dline_bus (
    input  logic        clk,
    input  logic        rst_n,
    dline_bus_if.master dl
`ifdef DLINE_BUS_PERF_EN
    ,
    output logic [31:0] rd_lines,
    output logic [31:0] wr_lines
`endif
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_t;

    state_t       state;
    logic [2:0]   cnt;
    logic [2:0]   cnt_nxt;
    logic [63:0]  line_addr;
    logic [511:0] wline;
    logic [511:0] rbuf;
    logic [511:0] rbuf_ins;

    assign cnt_nxt = cnt + 3'd1;

    // Read buffer with the current beat merged in; the last beat goes straight to drdata.
    always_comb begin
        rbuf_ins = rbuf;
        rbuf_ins[{cnt, 6'b0} +: 64] = dl.bus_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            line_addr    <= 64'd0;
            wline        <= 512'd0;
            rbuf         <= 512'd0;
            dl.drdata    <= 512'd0;
            dl.ddone     <= 1'b0;
            dl.bus_req   <= 1'b0;
            dl.bus_we    <= 1'b0;
            dl.bus_addr  <= 64'd0;
            dl.bus_wdata <= 64'd0;
`ifdef DLINE_BUS_PERF_EN
            rd_lines     <= 32'd0;
            wr_lines     <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dl.drequest) begin
                        line_addr   <= dl.daddr & 64'hFFFF_FFFF_FFFF_FFC0;
                        wline       <= dl.dwdata;
                        cnt         <= 3'd0;
                        dl.bus_req  <= 1'b1;
                        dl.bus_we   <= dl.dwrenable;
                        dl.bus_addr <= dl.daddr & 64'hFFFF_FFFF_FFFF_FFC0;
                        if (dl.dwrenable) begin
                            dl.bus_wdata <= dl.dwdata[63:0];
                            state        <= WR_DATA;
                        end else begin
                            state        <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (dl.bus_ready) begin
                        dl.bus_req <= 1'b0;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (dl.bus_rvalid) begin
                        rbuf <= rbuf_ins;
                        cnt  <= cnt_nxt;
                        if (cnt == 3'd7) begin
                            dl.drdata <= rbuf_ins;
                            dl.ddone  <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_DATA: begin
                    if (dl.bus_ready) begin
                        cnt <= cnt_nxt;
                        if (cnt == 3'd7) begin
                            dl.bus_req <= 1'b0;
                            dl.ddone   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            // Line address has zero low bits, so OR-ing the beat offset adds 8*k.
                            dl.bus_addr  <= line_addr | {55'd0, cnt_nxt, 6'd0} >> 3;
                            dl.bus_wdata <= wline[{cnt_nxt, 6'b0} +: 64];
                        end
                    end
                end
                DONE: begin
                    dl.ddone <= 1'b0;
                    state    <= IDLE;
`ifdef DLINE_BUS_PERF_EN
                    if (dl.bus_we) wr_lines <= wr_lines + 32'd1;
                    else           rd_lines <= rd_lines + 32'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dline_bus.sv
// Randomized bench for dline_bus: a transaction-level model predicts every bus beat, latency and line.
module tb_dline_bus;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dline_bus_if dl();

`ifdef DLINE_BUS_PERF_EN
    logic [31:0] rd_lines, wr_lines;
    dline_bus dut (.clk(clk), .rst_n(rst_n), .dl(dl), .rd_lines(rd_lines), .wr_lines(wr_lines));
`else
    dline_bus dut (.clk(clk), .rst_n(rst_n), .dl(dl));
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [511:0] exp_drdata = 512'd0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        dl.drequest   = 1'b0;
        dl.dwrenable  = 1'b0;
        dl.bus_ready  = 1'b0;
        dl.bus_rvalid = 1'b0;
        dl.bus_rdata  = 64'd0;
    endtask

    task automatic rand512(output logic [511:0] v);
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    endtask

    // Called at a negedge; issues a read and plays the bus side until ddone.
    task automatic do_read(input logic [63:0] addr, input logic [511:0] rline,
                           input int rdy_pct, input int val_pct, input bit stray,
                           input bit midreq, input int exp_lat);
        int c, n, last;
        bit acc;
        logic [63:0] line;
        logic [511:0] junk;
        line = addr & 64'hFFFF_FFFF_FFFF_FFC0;
        if (stray) begin
            dl.bus_rvalid = 1'b1;
            dl.bus_rdata  = {$urandom, $urandom};
            @(negedge clk);
            check("rd_idle_stray_ddone", dl.ddone, 0);
            dl.bus_rvalid = 1'b0;
        end
        rand512(junk);
        dl.drequest  = 1'b1;
        dl.dwrenable = 1'b0;
        dl.daddr     = addr;
        dl.dwdata    = junk;
        c = 0; n = 0; last = -1; acc = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            idle_inputs();
            if (c > 300) begin
                check("rd_timeout", dl.ddone, 1);
                break;
            end
            if (dl.ddone) begin
                check("rd_beats", n, 8);
                check("rd_done_cycle", c, last + 1);
                if (exp_lat > 0) check("rd_latency", c, exp_lat);
                check("rd_line", dl.drdata, rline);
                exp_drdata = rline;
                break;
            end
            check("rd_drdata_hold", dl.drdata, exp_drdata);
            if (!acc) begin
                check("rd_req", dl.bus_req, 1);
                if (dl.bus_req) begin
                    check("rd_we", dl.bus_we, 0);
                    check("rd_addr", dl.bus_addr, line);
                end
                dl.bus_ready = ($urandom_range(99) < rdy_pct);
                if (stray && $urandom_range(1) == 1) begin
                    dl.bus_rvalid = 1'b1;
                    dl.bus_rdata  = {$urandom, $urandom};
                end
                if (dl.bus_ready) acc = 1'b1;
            end else begin
                check("rd_req_low", dl.bus_req, 0);
                if (n < 8 && $urandom_range(99) < val_pct) begin
                    dl.bus_rvalid = 1'b1;
                    dl.bus_rdata  = rline[64*n +: 64];
                    n++;
                    last = c;
                end else if (midreq && n < 8 && $urandom_range(3) == 0) begin
                    dl.drequest  = 1'b1;
                    dl.dwrenable = 1'($urandom_range(1));
                end
            end
        end
        @(negedge clk);
        check("rd_ddone_single", dl.ddone, 0);
        rd_cnt++;
    endtask

    // mode 0: ready always high, 1: ready 1,0,1,0..., 2: random ready.
    task automatic do_write(input logic [63:0] addr, input logic [511:0] wline,
                            input int mode, input int exp_lat);
        int c, n, last;
        logic [63:0] line;
        line = addr & 64'hFFFF_FFFF_FFFF_FFC0;
        dl.drequest  = 1'b1;
        dl.dwrenable = 1'b1;
        dl.daddr     = addr;
        dl.dwdata    = wline;
        c = 0; n = 0; last = -1;
        forever begin
            @(negedge clk);
            c++;
            idle_inputs();
            if (c > 300) begin
                check("wr_timeout", dl.ddone, 1);
                break;
            end
            if (dl.ddone) begin
                check("wr_beats", n, 8);
                check("wr_done_cycle", c, last + 1);
                if (exp_lat > 0) check("wr_latency", c, exp_lat);
                check("wr_drdata_unchanged", dl.drdata, exp_drdata);
                break;
            end
            check("wr_req", dl.bus_req, 1);
            check("wr_we", dl.bus_we, 1);
            check("wr_addr", dl.bus_addr, line + 64'(8 * n));
            check("wr_data", dl.bus_wdata, wline[64*n +: 64]);
            case (mode)
                0:       dl.bus_ready = 1'b1;
                1:       dl.bus_ready = (c % 2 == 1);
                default: dl.bus_ready = 1'($urandom_range(1));
            endcase
            if (dl.bus_ready) begin
                n++;
                last = c;
            end
        end
        @(negedge clk);
        check("wr_ddone_single", dl.ddone, 0);
        wr_cnt++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_drdata"}, dl.drdata, 0);
        check({tag, "_ddone"}, dl.ddone, 0);
        check({tag, "_bus_req"}, dl.bus_req, 0);
        check({tag, "_bus_we"}, dl.bus_we, 0);
        check({tag, "_bus_addr"}, dl.bus_addr, 0);
        check({tag, "_bus_wdata"}, dl.bus_wdata, 0);
    endtask

    // Read aborted by reset while its fifth beat is being delivered.
    task automatic do_reset_mid_read();
        logic [511:0] rline;
        rand512(rline);
        dl.drequest = 1'b1;
        dl.dwrenable = 1'b0;
        dl.daddr = 64'h0000_0000_1234_5680;
        @(negedge clk);
        idle_inputs();
        dl.bus_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            dl.bus_rvalid = 1'b1;
            dl.bus_rdata  = rline[64*k +: 64];
        end
        @(negedge clk);
        dl.bus_rdata = rline[64*4 +: 64];
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_drdata = 512'd0;
        rd_cnt = 0;
        wr_cnt = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_ddone", dl.ddone, 0);
        end
    endtask

    initial begin
        logic [511:0] line;
        idle_inputs();
        dl.daddr  = 64'd0;
        dl.dwdata = 512'd0;
        #12;
        check_reset_outputs("reset");
`ifdef DLINE_BUS_PERF_EN
        check("reset_rd_lines", rd_lines, 0);
        check("reset_wr_lines", wr_lines, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) line[64*k +: 64] = 64'h1000 + 64'(k);
        do_read(64'h0000_0000_4000_0037, line, 100, 100, 1'b0, 1'b0, 10);

        for (int k = 0; k < 8; k++) line[64*k +: 64] = 64'hA0 + 64'(k);
        do_write(64'h0000_0000_4000_0040, line, 0, 9);

        rand512(line);
        do_write(64'h0000_0000_0000_0100, line, 1, 0);

        rand512(line);
        do_read(64'h0000_0000_8000_00C5, line, 50, 50, 1'b1, 1'b1, 0);

        do_reset_mid_read();

        rand512(line);
        do_read(64'h0000_0000_4000_0000, line, 100, 100, 1'b0, 1'b0, 10);

        for (int i = 0; i < 10; i++) begin
            rand512(line);
            if (i < 2 || (i >= 5 && $urandom_range(1) == 1))
                do_read({$urandom, $urandom}, line, 60, 60, 1'b1, 1'b1, 0);
            else
                do_write({$urandom, $urandom}, line, 2, 0);
        end

`ifdef DLINE_BUS_PERF_EN
        check("perf_rd_lines", rd_lines, rd_cnt);
        check("perf_wr_lines", wr_lines, wr_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
